// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg -- shared definitions for the shift issue stage.
//   DATA_W       operand width of the downstream shifter bank (20 bits)
//   AMT_W        width of the raw and normalized shift amount
//   shift_op_e   request opcode encoding on InOp (5..7 are illegal)
//   MODE_*       ShifterMode values, one per shifter instance
//   shift_req_t  normalized request as held in the request buffer
// ---------------------------------------------------------------------------
package shift_pkg;

    localparam int DATA_W = 20;
    localparam int AMT_W  = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'd0,
        OP_ROL = 3'd1,
        OP_SRL = 3'd2,
        OP_SRA = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    localparam logic [OP_W-1:0] MODE_SLL = 3'd0;
    localparam logic [OP_W-1:0] MODE_ROL = 3'd1;
    localparam logic [OP_W-1:0] MODE_SRL = 3'd2;
    localparam logic [OP_W-1:0] MODE_SRA = 3'd3;
    localparam logic [OP_W-1:0] MODE_ROR = 3'd4;

    // force_res: downstream discards the shifter result and emits all-fill bits
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amount;
        logic [OP_W-1:0]   mode;
        logic              force_res;
        logic              fill;
        logic              illegal;
    } shift_req_t;

endpackage

// File: rtl/shift_req_fifo.sv
// ---------------------------------------------------------------------------
// shift_req_fifo -- small request buffer for normalized shift requests.
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset, empties the buffer
//   push_i      write push_data_i (ignored when full)
//   push_data_i normalized request
//   pop_i       drop the head entry (ignored when empty)
//   full_o      DEPTH entries held
//   empty_o     no entries held
//   head_o      oldest entry, read straight from storage
// ---------------------------------------------------------------------------
module shift_req_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  shift_req_t push_data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output shift_req_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    shift_req_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is reset so the Out* bus reads all-zero while held in reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q[gi] <= '0;
            end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/shift_issue_stage.sv
// ---------------------------------------------------------------------------
// shift_issue_stage -- normalizes shift requests and queues them for a bank
// of five fixed-function 20-bit shifters.
//   Clock, nReset        clock (rising edge), asynchronous active-low reset
//   InValid/InReady      upstream handshake
//   InData/InAmount/InOp raw operand, amount 0..31, opcode
//   OutValid/OutReady    downstream handshake on the oldest buffered request
//   OutData/OutAmount    operand and normalized amount 0..19
//   OutMode              shifter instance select
//   OutForce/OutFill     replace the shifter result by all-OutFill bits
//   OutIllegal           head request carried an unsupported opcode
//   ReqCount             wrapping count of accepted requests
// Build option: define SHIFT_ROTATE_EN to support ROL/ROR; otherwise those
// opcodes are handled as illegal.
// ---------------------------------------------------------------------------
module shift_issue_stage #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 2
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [4:0]        InAmount,
    input  logic [2:0]        InOp,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [4:0]        OutAmount,
    output logic [2:0]        OutMode,
    output logic              OutForce,
    output logic              OutFill,
    output logic              OutIllegal,
    output logic [15:0]       ReqCount
);

    import shift_pkg::*;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    shift_req_t  req_d;
    shift_req_t  head;
    logic        fifo_full, fifo_empty;
    logic        rdy_q;
    logic [15:0] req_cnt_q, req_cnt_d;
    logic        is_rot, legal, big_amt, accept, pop;

    // Normalization: every request leaves here with an amount the 20-bit
    // shifters can use directly; out-of-range shifts become forced fills.
    always_comb begin
        req_d      = '0;
        req_d.data = InData;
        is_rot     = (InOp == OP_ROL) || (InOp == OP_ROR);
        legal      = (InOp == OP_SLL) || (InOp == OP_SRL) || (InOp == OP_SRA)
                     || (is_rot && ROT_EN);
        big_amt    = (InAmount >= 5'd20);
        if (!legal) begin
            req_d.illegal   = 1'b1;
            req_d.force_res = 1'b1;
        end else begin
            req_d.mode = InOp;
            if (!big_amt) begin
                req_d.amount = InAmount;
            end else if (is_rot) begin
                // Rotation by 20..31 equals rotation by amount-20.
                req_d.amount = InAmount - 5'd20;
            end else begin
                req_d.force_res = 1'b1;
                req_d.fill      = (InOp == OP_SRA) & InData[DATA_W-1];
            end
        end
    end

    // rdy_q keeps InReady low until the first edge after reset release.
    assign InReady   = rdy_q & ~fifo_full;
    assign accept    = InValid & InReady;
    assign OutValid  = ~fifo_empty;
    assign pop       = OutValid & OutReady;
    assign req_cnt_d = accept ? req_cnt_q + 16'd1 : req_cnt_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rdy_q     <= 1'b0;
            req_cnt_q <= '0;
        end else begin
            rdy_q     <= 1'b1;
            req_cnt_q <= req_cnt_d;
        end
    end

    shift_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (Clock),
        .rst_ni      (nReset),
        .push_i      (accept),
        .push_data_i (req_d),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (head)
    );

    assign OutData    = head.data;
    assign OutAmount  = head.amount;
    assign OutMode    = head.mode;
    assign OutForce   = head.force_res;
    assign OutFill    = head.fill;
    assign OutIllegal = head.illegal;
    assign ReqCount   = req_cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_issue_stage -- randomized and directed bench for shift_issue_stage
// against a queue-based reference model of the request buffer.
// ---------------------------------------------------------------------------
module tb_shift_issue_stage;

    logic        Clock;
    logic        nReset;
    logic        InValid;
    logic        InReady;
    logic [19:0] InData;
    logic [4:0]  InAmount;
    logic [2:0]  InOp;
    logic        OutValid;
    logic        OutReady;
    logic [19:0] OutData;
    logic [4:0]  OutAmount;
    logic [2:0]  OutMode;
    logic        OutForce;
    logic        OutFill;
    logic        OutIllegal;
    logic [15:0] ReqCount;

    shift_issue_stage #(.DATA_W(20), .DEPTH(2)) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .InValid    (InValid),
        .InReady    (InReady),
        .InData     (InData),
        .InAmount   (InAmount),
        .InOp       (InOp),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutData    (OutData),
        .OutAmount  (OutAmount),
        .OutMode    (OutMode),
        .OutForce   (OutForce),
        .OutFill    (OutFill),
        .OutIllegal (OutIllegal),
        .ReqCount   (ReqCount)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

`ifdef SHIFT_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct {
        logic [19:0] d;
        logic [4:0]  amt;
        logic [2:0]  mode;
        logic        frc;
        logic        fill;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    logic [15:0] cnt_m;
    bit          ready_m;
    bit          quiet;
    int          errors;
    int          checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected normalized request, straight from the opcode/amount rules.
    function automatic exp_t model_norm(input logic [19:0] d, input int amt, input int op);
        exp_t e;
        bit   rot;
        e.d = d; e.amt = 0; e.mode = 0; e.frc = 0; e.fill = 0; e.ill = 0;
        rot = (op == 1) || (op == 4);
        if (op > 4 || (rot && !ROT_EN)) begin
            e.ill = 1; e.frc = 1;
        end else begin
            e.mode = 3'(op);
            if (amt < 20)      e.amt = 5'(amt);
            else if (rot)      e.amt = 5'(amt % 20);
            else begin
                e.frc  = 1;
                e.fill = (op == 3) ? d[19] : 1'b0;
            end
        end
        return e;
    endfunction

    task automatic model_step();
        bit acc, pp;
        if (nReset) begin
            acc = InValid && ready_m && (q.size() < 2);
            pp  = (q.size() > 0) && OutReady;
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back(model_norm(InData, int'(InAmount), int'(InOp)));
                cnt_m = cnt_m + 16'd1;
                if (!quiet)
                    $display("txn %0d: op=%0d amt=%0d data=%05h", cnt_m, InOp, InAmount, InData);
            end
            ready_m = 1;
        end
    endtask

    task automatic check_all();
        check("in_ready", 32'(InReady), 32'(ready_m && q.size() < 2));
        check("out_valid", 32'(OutValid), 32'(q.size() > 0));
        check("req_count", 32'(ReqCount), 32'(cnt_m));
        if (q.size() > 0) begin
            check("out_data", 32'(OutData), 32'(q[0].d));
            check("out_amount", 32'(OutAmount), 32'(q[0].amt));
            check("out_mode", 32'(OutMode), 32'(q[0].mode));
            check("out_force", 32'(OutForce), 32'(q[0].frc));
            check("out_fill", 32'(OutFill), 32'(q[0].fill));
            check("out_illegal", 32'(OutIllegal), 32'(q[0].ill));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(InReady), 32'd0);
        check({tag, "_out_valid"}, 32'(OutValid), 32'd0);
        check({tag, "_req_count"}, 32'(ReqCount), 32'd0);
        check({tag, "_out_bus"}, 32'({OutData, OutAmount, OutMode, OutForce, OutFill, OutIllegal}), 32'd0);
    endtask

    // Drive at the falling edge, update the model on the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit v, input logic [19:0] d, input logic [4:0] a,
                         input logic [2:0] op, input bit ordy);
        InValid = v; InData = d; InAmount = a; InOp = op; OutReady = ordy;
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        if (!quiet) check_all();
    endtask

    task automatic model_reset();
        q.delete();
        cnt_m   = '0;
        ready_m = 0;
    endtask

    initial begin
        logic [15:0] prev;
        int          guard;
        errors = 0; checks = 0; quiet = 0;
        nReset = 0; InValid = 0; InData = '0; InAmount = '0; InOp = '0; OutReady = 0;
        model_reset();

        #2 check_reset_outputs("reset");
        @(negedge Clock); @(negedge Clock);
        check_reset_outputs("reset_hold");
        nReset = 1;

        // Ready comes up on the first edge after release.
        cycle(0, '0, '0, '0, 0);
        check("ready_after_reset", 32'(InReady), 32'd1);

        // Back-pressure: three back-to-back requests, only two fit.
        cycle(1, 20'h12345, 5'd3, 3'd0, 0);
        cycle(1, 20'h11111, 5'd4, 3'd2, 0);
        cycle(1, 20'h22222, 5'd5, 3'd3, 0);
        check("bp_req_count", 32'(ReqCount), 32'd2);
        check("bp_in_ready", 32'(InReady), 32'd0);
        cycle(0, '0, '0, '0, 0);
        check("bp_stable_data", 32'(OutData), 32'h12345);
        check("bp_stable_amount", 32'(OutAmount), 32'd3);
        cycle(0, '0, '0, '0, 1);
        cycle(0, '0, '0, '0, 1);

        // SRA of a negative operand past the width.
        cycle(1, 20'h80000, 5'd25, 3'd3, 0);
        check("sra_force", 32'(OutForce), 32'd1);
        check("sra_fill", 32'(OutFill), 32'd1);
        check("sra_amount", 32'(OutAmount), 32'd0);
        check("sra_mode", 32'(OutMode), 32'd3);
        cycle(0, '0, '0, '0, 1);

        // ROR by 23.
        cycle(1, 20'h0F0F0, 5'd23, 3'd4, 0);
        if (ROT_EN) begin
            check("ror_amount", 32'(OutAmount), 32'd3);
            check("ror_mode", 32'(OutMode), 32'd4);
            check("ror_force", 32'(OutForce), 32'd0);
        end else begin
            check("ror_illegal", 32'(OutIllegal), 32'd1);
        end
        cycle(0, '0, '0, '0, 1);

        // One entry held, push and pop together.
        cycle(1, 20'hAAAAA, 5'd2, 3'd0, 0);
        prev = cnt_m;
        cycle(1, 20'h55555, 5'd7, 3'd2, 1);
        check("pp_out_valid", 32'(OutValid), 32'd1);
        check("pp_new_head", 32'(OutData), 32'h55555);
        check("pp_req_count", 32'(ReqCount), 32'(prev + 16'd1));
        cycle(0, '0, '0, '0, 1);

        // Illegal opcode.
        cycle(1, 20'hABCDE, 5'd9, 3'd6, 0);
        check("ill_flag", 32'(OutIllegal), 32'd1);
        check("ill_force", 32'(OutForce), 32'd1);
        check("ill_fill", 32'(OutFill), 32'd0);
        check("ill_mode", 32'(OutMode), 32'd0);
        check("ill_amount", 32'(OutAmount), 32'd0);
        cycle(0, '0, '0, '0, 1);

        // Random traffic with a reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                cycle(1, 20'h13579, 5'd1, 3'd0, 0);
                nReset = 0;
                #1;
                check_reset_outputs("mid_reset");
                model_reset();
                cycle(1, 20'h24680, 5'd2, 3'd2, 1);
                nReset = 1;
            end
            cycle(($urandom_range(0, 3) != 0), 20'($urandom), 5'($urandom_range(0, 31)),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
        end

        // Run the counter up to its wrap point.
        quiet = 1;
        guard = 0;
        while (cnt_m != 16'hFFFF && guard < 70000) begin
            cycle(1, 20'($urandom), 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 1);
            guard++;
        end
        quiet = 0;
        check("wrap_reached", 32'(cnt_m), 32'hFFFF);
        check("count_max", 32'(ReqCount), 32'hFFFF);
        cycle(1, 20'h00001, 5'd19, 3'd0, 1);
        check("count_wrap", 32'(ReqCount), 32'd0);
        cycle(0, '0, '0, '0, 1);
        cycle(0, '0, '0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 20, operand width; only 20 is supported.
REQ-002 SHALL have parameter DEPTH, default 2, request buffer entries; only 2 is supported.
REQ-003 SHALL have port Clock  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nReset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port InValid  in  1  upstream request valid.
REQ-006 SHALL have port InReady  out  1  stage can accept a request.
REQ-007 SHALL have port InData  in  20  operand to shift.
REQ-008 SHALL have port InAmount  in  5  raw shift amount, 0..31.
REQ-009 SHALL have port InOp  in  3  0 SLL, 1 ROL, 2 SRL, 3 SRA, 4 ROR, 5..7 illegal.
REQ-010 SHALL have port OutValid  out  1  request available to shifter bank.
REQ-011 SHALL have port OutReady  in  1  shifter bank consumes head request.
REQ-012 SHALL have port OutData  out  20  operand for the 20-bit shifter DataA input.
REQ-013 SHALL have port OutAmount  out  5  normalized ShiftAmount, always 0..19.
REQ-014 SHALL have port OutMode  out  3  ShifterMode selecting one of five shifter instances.
REQ-015 SHALL have port OutForce  out  1  downstream replaces the shifter result with all-OutFill bits.
REQ-016 SHALL have port OutFill  out  1  fill bit used when OutForce=1.
REQ-017 SHALL have port OutIllegal  out  1  head request carried an illegal InOp.
REQ-018 SHALL have port ReqCount  out  16  number of requests accepted since reset, wrapping.

Function
REQ-019 SHALL accept a request on a rising edge with InValid=1 and InReady=1.
REQ-020 SHALL drive InReady=1 exactly when fewer than 2 entries are held; no full-state pass-through.
REQ-021 SHALL drive OutValid=1 exactly when at least 1 entry is held; outputs reflect the oldest entry.
REQ-022 SHALL pop the head on a rising edge with OutValid=1 and OutReady=1.
REQ-023 SHALL present a request accepted into an empty buffer on Out* one cycle after acceptance.
REQ-024 SHALL keep the entry count unchanged when a push and pop happen in the same cycle with one entry held.
REQ-025 SHALL hold all Out* stable while OutValid=1 and OutReady=0.
REQ-026 SHALL normalize on accept: ROL/ROR amounts of 20..31 become amount-20, with OutForce=0.
REQ-027 SHALL handle SLL/SRL amount>=20 as OutForce=1, OutFill=0, OutAmount=0.
REQ-028 SHALL handle SRA amount>=20 as OutForce=1, OutFill=InData[19], OutAmount=0.
REQ-029 SHALL handle amounts below 20 as passed unchanged with OutForce=0, OutFill=0.
REQ-030 SHALL handle an illegal InOp as accepted with OutIllegal=1, OutMode=0, OutAmount=0, OutForce=1, OutFill=0.
REQ-031 SHALL increment ReqCount on every accept, wrapping from 0xFFFF to 0.

Reset
REQ-032 SHALL, while nReset=0, asynchronously empty the buffer and drive InReady=0, OutValid=0, ReqCount=0, and all other outputs 0.
REQ-033 SHALL drive InReady=1 on the first rising edge after nReset deasserts; in-flight requests at reset are discarded.

Configuration
REQ-034 SHALL, with SHIFT_ROTATE_EN defined, support ROL/ROR as specified.
REQ-035 SHALL, without SHIFT_ROTATE_EN, treat InOp 1 and 4 as illegal per REQ-030.

Structure
REQ-036 SHALL take the op encodings, ShifterMode constants 0..4 and DATA_W from shared package shift_pkg.
REQ-037 SHALL implement buffering in sub-module shift_req_fifo, with normalization in shift_issue_stage before the push.

Verification
REQ-038 SHALL verify: SRA InData=0x80000, InAmount=25 -> next cycle OutForce=1, OutFill=1, OutAmount=0, OutMode=3.
REQ-039 SHALL verify: ROR InAmount=23 -> OutAmount=3, OutMode=4, OutForce=0; without SHIFT_ROTATE_EN -> OutIllegal=1.
REQ-040 SHALL verify: OutReady=0 and three back-to-back requests -> two accepted, InReady=0, Out* stable, ReqCount=2.
REQ-041 SHALL verify: one entry held, simultaneous push and pop -> OutValid stays 1, new head next cycle, ReqCount+1.
REQ-042 SHALL verify: InOp=6 -> OutIllegal=1, OutForce=1, OutFill=0; nReset low mid-stream -> OutValid=0 immediately, ReqCount=0.
